// File: rtl/cv32e40x_clic_source_arbiter_if.sv
// Bundle between the CLIC source arbiter and its neighbours: the
// per-source configuration write port, the core's acknowledge, and the
// clic_irq_* lines presented to the core.
interface cv32e40x_clic_source_arbiter_if #(
  parameter int CLIC_ID_WIDTH = 5
);
  logic                     cfg_we_i;
  logic [CLIC_ID_WIDTH-1:0] cfg_id_i;
  logic                     cfg_ie_i;
  logic                     cfg_edge_i;
  logic                     cfg_ip_set_i;
  logic [7:0]               cfg_level_i;
  logic                     cfg_shv_i;
  logic                     irq_ack_i;
  logic [CLIC_ID_WIDTH-1:0] irq_ack_id_i;
  logic                     clic_irq_o;
  logic [CLIC_ID_WIDTH-1:0] clic_irq_id_o;
  logic [7:0]               clic_irq_level_o;
  logic [1:0]               clic_irq_priv_o;
  logic                     clic_irq_shv_o;

  // Arbiter side
  modport slave (
    input  cfg_we_i, cfg_id_i, cfg_ie_i, cfg_edge_i, cfg_ip_set_i,
           cfg_level_i, cfg_shv_i, irq_ack_i, irq_ack_id_i,
    output clic_irq_o, clic_irq_id_o, clic_irq_level_o,
           clic_irq_priv_o, clic_irq_shv_o
  );

  // Configuration master / core side
  modport master (
    output cfg_we_i, cfg_id_i, cfg_ie_i, cfg_edge_i, cfg_ip_set_i,
           cfg_level_i, cfg_shv_i, irq_ack_i, irq_ack_id_i,
    input  clic_irq_o, clic_irq_id_o, clic_irq_level_o,
           clic_irq_priv_o, clic_irq_shv_o
  );
endinterface

// File: rtl/cv32e40x_clic_source_arbiter.sv
// Interrupt-source end of the CLIC: per-source pending/enable/trigger/
// level/shv state, a max-level (ties -> highest ID) arbiter over all
// eligible sources, and a registered presentation of the winner to the core.
module cv32e40x_clic_source_arbiter #(
  parameter int NUM_IRQ       = 32,
  parameter int CLIC_ID_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_IRQ-1:0]                    irq_src_i,
  cv32e40x_clic_source_arbiter_if.slave         bus
);

  logic [NUM_IRQ-1:0]       ie_q;
  logic [NUM_IRQ-1:0]       edge_q, edge_d;
  logic [NUM_IRQ-1:0]       ip_q, ip_d;
  logic [NUM_IRQ-1:0]       shv_q;
  logic [NUM_IRQ-1:0]       src_q;
  logic [7:0]               level_q [NUM_IRQ];

  logic [NUM_IRQ-1:0]       cfg_hit;
  logic [NUM_IRQ-1:0]       ack_hit;
  logic [NUM_IRQ-1:0]       ip_set;
  logic [NUM_IRQ-1:0]       pend;
  logic [NUM_IRQ-1:0]       elig;

  logic                     win_vld;
  logic [CLIC_ID_WIDTH-1:0] win_id;
  logic [7:0]               win_level;
  logic                     win_shv;

  logic                     irq_q;
  logic [CLIC_ID_WIDTH-1:0] id_q;
  logic [7:0]               lvl_q;
  logic                     oshv_q;

  // Per-source next pending state and eligibility. Stored ip is only
  // meaningful for edge sources; a level source reads its line directly.
  // An acked edge source is masked in the ack cycle unless a new set
  // arrives at the same time (set wins, so it stays presented).
  always_comb begin
    cfg_hit = '0;
    ack_hit = '0;
    ip_set  = '0;
    pend    = '0;
    elig    = '0;
    edge_d  = edge_q;
    ip_d    = ip_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      cfg_hit[i] = bus.cfg_we_i  && (bus.cfg_id_i     == CLIC_ID_WIDTH'(i));
      ack_hit[i] = bus.irq_ack_i && (bus.irq_ack_id_i == CLIC_ID_WIDTH'(i));
      edge_d[i]  = cfg_hit[i] ? bus.cfg_edge_i : edge_q[i];
      ip_set[i]  = edge_d[i] &&
                   ((irq_src_i[i] && !src_q[i]) || (cfg_hit[i] && bus.cfg_ip_set_i));
      if (ip_set[i])
        ip_d[i] = 1'b1;
      else if (!edge_d[i] || ack_hit[i])
        ip_d[i] = 1'b0;
      else
        ip_d[i] = ip_q[i];
      pend[i] = edge_q[i] ? ip_q[i] : irq_src_i[i];
      elig[i] = pend[i] && ie_q[i] && (level_q[i] != 8'd0) &&
                !(edge_q[i] && ack_hit[i] && !ip_set[i]);
    end
  end

  // Arbitration: ascending scan with >= so the highest ID wins level ties.
  always_comb begin
    win_vld   = 1'b0;
    win_id    = '0;
    win_level = 8'd0;
    win_shv   = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig[i] && (level_q[i] >= win_level)) begin
        win_vld   = 1'b1;
        win_id    = CLIC_ID_WIDTH'(i);
        win_level = level_q[i];
        win_shv   = shv_q[i];
      end
    end
  end

  // Per-source configuration, pending and input history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q   <= '0;
      edge_q <= '0;
      ip_q   <= '0;
      shv_q  <= '0;
      src_q  <= '0;
      for (int i = 0; i < NUM_IRQ; i++) level_q[i] <= 8'd0;
    end else begin
      edge_q <= edge_d;
      ip_q   <= ip_d;
      src_q  <= irq_src_i;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cfg_hit[i]) begin
          ie_q[i]    <= bus.cfg_ie_i;
          shv_q[i]   <= bus.cfg_shv_i;
          level_q[i] <= bus.cfg_level_i;
        end
      end
    end
  end

  // Output register: valid every cycle, id/level/shv hold when nothing wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q  <= 1'b0;
      id_q   <= '0;
      lvl_q  <= 8'd0;
      oshv_q <= 1'b0;
    end else begin
      irq_q <= win_vld;
      if (win_vld) begin
        id_q   <= win_id;
        lvl_q  <= win_level;
        oshv_q <= win_shv;
      end
    end
  end

  assign bus.clic_irq_o       = irq_q;
  assign bus.clic_irq_id_o    = id_q;
  assign bus.clic_irq_level_o = lvl_q;
  assign bus.clic_irq_shv_o   = oshv_q;
  assign bus.clic_irq_priv_o  = 2'b11;

endmodule

// File: tb/tb_cv32e40x_clic_source_arbiter.sv
// Directed bench for the CLIC source arbiter: edge/level pending, priority
// and tie-break, preemption, ack masking, set-vs-clear, level-0 and reset.
module tb_cv32e40x_clic_source_arbiter;

  localparam int NUM_IRQ = 32;
  localparam int IDW     = 5;

  logic               clk;
  logic               rst;
  logic [NUM_IRQ-1:0] irq_src;
  int                 n_cmp;
  int                 n_err;

  cv32e40x_clic_source_arbiter_if #(.CLIC_ID_WIDTH(IDW)) bus ();

  cv32e40x_clic_source_arbiter #(
    .NUM_IRQ      (NUM_IRQ),
    .CLIC_ID_WIDTH(IDW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src_i(irq_src),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int id, input logic ie, input logic edg, input logic ipset,
                     input logic [7:0] lvl, input logic shv);
    bus.cfg_we_i     = 1'b1;
    bus.cfg_id_i     = IDW'(id);
    bus.cfg_ie_i     = ie;
    bus.cfg_edge_i   = edg;
    bus.cfg_ip_set_i = ipset;
    bus.cfg_level_i  = lvl;
    bus.cfg_shv_i    = shv;
    step();
    bus.cfg_we_i     = 1'b0;
    bus.cfg_ip_set_i = 1'b0;
  endtask

  task automatic ack(input int id);
    bus.irq_ack_i    = 1'b1;
    bus.irq_ack_id_i = IDW'(id);
    step();
    bus.irq_ack_i    = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic irq, input int id, input logic [7:0] lvl);
    chk({tag, ".irq"}, 32'(bus.clic_irq_o), 32'(irq));
    chk({tag, ".id"},  32'(bus.clic_irq_id_o), 32'(id));
    chk({tag, ".lvl"}, 32'(bus.clic_irq_level_o), 32'(lvl));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    irq_src = '0;
    bus.cfg_we_i = 1'b0; bus.cfg_id_i = '0; bus.cfg_ie_i = 1'b0; bus.cfg_edge_i = 1'b0;
    bus.cfg_ip_set_i = 1'b0; bus.cfg_level_i = 8'd0; bus.cfg_shv_i = 1'b0;
    bus.irq_ack_i = 1'b0; bus.irq_ack_id_i = '0;
    step();
    step();
    chk_out("reset", 1'b0, 0, 8'h00);
    chk("reset.priv", 32'(bus.clic_irq_priv_o), 32'h3);
    chk("reset.shv",  32'(bus.clic_irq_shv_o), 32'h0);
    rst = 1'b0;
    step();

    // 1: edge source 3, two-cycle latency, ack clears
    cfg(3, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0);
    irq_src[3] = 1'b1;
    step();
    chk("t1.n1.irq", 32'(bus.clic_irq_o), 32'h0);
    irq_src[3] = 1'b0;
    step();
    chk_out("t1.n2", 1'b1, 3, 8'h40);
    ack(3);
    chk("t1.ack.irq", 32'(bus.clic_irq_o), 32'h0);
    step();
    chk("t1.after.irq", 32'(bus.clic_irq_o), 32'h0);

    // 2: level sources 5 (0x20, shv) and 9 (0x80); disable 9 -> 5
    cfg(5, 1'b1, 1'b0, 1'b0, 8'h20, 1'b1);
    cfg(9, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0);
    irq_src[5] = 1'b1;
    irq_src[9] = 1'b1;
    step();
    chk_out("t2.hi", 1'b1, 9, 8'h80);
    chk("t2.hi.shv", 32'(bus.clic_irq_shv_o), 32'h0);
    cfg(9, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0);
    chk("t2.dis0.id", 32'(bus.clic_irq_id_o), 32'd9);
    step();
    chk_out("t2.lo", 1'b1, 5, 8'h20);
    chk("t2.lo.shv", 32'(bus.clic_irq_shv_o), 32'h1);
    irq_src[5] = 1'b0;
    irq_src[9] = 1'b0;
    step();
    chk_out("t2.idle.hold", 1'b0, 5, 8'h20);

    // 3: tie at 0x30 between edge 4 and 7 -> 7; ack 7 -> 4
    cfg(4, 1'b1, 1'b1, 1'b1, 8'h30, 1'b0);
    cfg(7, 1'b1, 1'b1, 1'b1, 8'h30, 1'b0);
    step();
    chk_out("t3.tie", 1'b1, 7, 8'h30);
    ack(7);
    chk_out("t3.ack7", 1'b1, 4, 8'h30);
    step();
    chk_out("t3.after1", 1'b1, 4, 8'h30);
    step();
    chk_out("t3.after2", 1'b1, 4, 8'h30);
    ack(4);
    chk("t3.ack4.irq", 32'(bus.clic_irq_o), 32'h0);

    // 4: level source 2 acked stays presented; line low -> drops
    cfg(2, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
    irq_src[2] = 1'b1;
    step();
    chk_out("t4.on", 1'b1, 2, 8'h10);
    ack(2);
    chk_out("t4.acked", 1'b1, 2, 8'h10);
    irq_src[2] = 1'b0;
    step();
    chk("t4.off.irq", 32'(bus.clic_irq_o), 32'h0);

    // 5: edge source 6, new rising edge coincident with ack -> set wins
    cfg(6, 1'b1, 1'b1, 1'b0, 8'h50, 1'b0);
    irq_src[6] = 1'b1;
    step();
    irq_src[6] = 1'b0;
    step();
    chk_out("t5.pres", 1'b1, 6, 8'h50);
    irq_src[6] = 1'b1;
    ack(6);
    chk_out("t5.setwins", 1'b1, 6, 8'h50);
    step();
    chk_out("t5.still", 1'b1, 6, 8'h50);
    ack(6);
    chk("t5.cleared.irq", 32'(bus.clic_irq_o), 32'h0);
    irq_src[6] = 1'b0;

    // 6: level-0 source never presented; async reset mid-stream
    cfg(10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    irq_src[10] = 1'b1;
    step();
    step();
    chk("t6.lvl0.irq", 32'(bus.clic_irq_o), 32'h0);
    irq_src[2] = 1'b1;
    step();
    chk_out("t6.pre", 1'b1, 2, 8'h10);
    rst = 1'b1;
    #1;
    chk_out("t6.rst", 1'b0, 0, 8'h00);
    chk("t6.rst.priv", 32'(bus.clic_irq_priv_o), 32'h3);
    chk("t6.rst.shv",  32'(bus.clic_irq_shv_o), 32'h0);
    rst = 1'b0;
    step();
    step();
    chk("t6.post.irq", 32'(bus.clic_irq_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
